// File: rtl/trigger_match.sv
// trigger_match: mcontrol (type 2) state for two hardware triggers, execute
// and load/store address compare against tdata2, and a registered
// breakpoint/debug-entry request held until acknowledged.
// Optional build macro: TRIGGER_NAPOT_MATCH_EN enables match=1 (NAPOT).
module trigger_match #(
  parameter int unsigned NUM_TRIG = 2,
  parameter int unsigned DW       = 32
) (
  input  logic          cpu_clk,
  input  logic          cpu_rstn,
  input  logic          tselect,
  input  logic          mctrl_wr,
  input  logic [DW-1:0] mctrl_wr_data,
  output logic [DW-1:0] mctrl_rd_data,
  input  logic [DW-1:0] tdata2_t0,
  input  logic [DW-1:0] tdata2_t1,
  input  logic          dbg_mode,
  input  logic          if_pc_valid,
  input  logic [DW-1:0] if_pc,
  input  logic          ls_valid,
  input  logic          ls_store,
  input  logic [DW-1:0] ls_addr,
  output logic          trig_req,
  output logic          trig_action,
  output logic          trig_idx,
  output logic          trig_is_ls,
  input  logic          trig_ack
);

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_TRIG-1:0] r_dmode;
  logic [NUM_TRIG-1:0] r_hit;
  logic [NUM_TRIG-1:0] r_action;
  logic [NUM_TRIG-1:0] r_chain;
  logic [NUM_TRIG-1:0] r_m;
  logic [NUM_TRIG-1:0] r_exec;
  logic [NUM_TRIG-1:0] r_store;
  logic [NUM_TRIG-1:0] r_load;
  logic [3:0]          r_match [NUM_TRIG];

  logic                r_trig_action;
  logic                r_trig_idx;
  logic                r_trig_is_ls;

  logic [DW-1:0]       w_tdata2 [NUM_TRIG];
  logic [NUM_TRIG-1:0] w_exe_raw;
  logic [NUM_TRIG-1:0] w_ls_raw;
  logic [NUM_TRIG-1:0] w_exe_fire;
  logic [NUM_TRIG-1:0] w_ls_fire;
  logic [NUM_TRIG-1:0] w_set_hit;
  logic                w_any;
  logic                w_idx;
  logic                w_is_ls;
  logic                w_take;
  logic                w_wr_ok;
  logic                w_unused;

  // Address compare for one source against one trigger's tdata2.
  function automatic logic f_cmp(input logic [DW-1:0] v, input logic [DW-1:0] t,
                                 input logic [3:0] mt);
`ifdef TRIGGER_NAPOT_MATCH_EN
    logic [DW-1:0] msk;
    // t ^ (t+1) covers the k trailing ones plus the zero above them
    msk = t ^ (t + DW'(1));
`endif
    f_cmp = 1'b0;
    case (mt)
      4'd0: f_cmp = (v == t);
`ifdef TRIGGER_NAPOT_MATCH_EN
      4'd1: f_cmp = ((v & ~msk) == (t & ~msk));
`endif
      4'd2: f_cmp = (v >= t);
      4'd3: f_cmp = (v < t);
      default: f_cmp = 1'b0;
    endcase
  endfunction

  assign w_tdata2[0] = tdata2_t0;
  assign w_tdata2[1] = tdata2_t1;

  // A trigger owned by debug mode cannot be modified from outside debug mode
  assign w_wr_ok  = !(r_dmode[tselect] && !dbg_mode);
  assign w_unused = ^{mctrl_wr_data[31:28], mctrl_wr_data[26:21],
                      mctrl_wr_data[19:16], mctrl_wr_data[5:3]};

  for (genvar g = 0; g < NUM_TRIG; g++) begin : g_trig
    assign w_exe_raw[g] = !dbg_mode && r_m[g] && r_exec[g] && if_pc_valid &&
                          f_cmp(if_pc, w_tdata2[g], r_match[g]);
    assign w_ls_raw[g]  = !dbg_mode && r_m[g] && ls_valid &&
                          ((r_load[g] && !ls_store) || (r_store[g] && ls_store)) &&
                          f_cmp(ls_addr, w_tdata2[g], r_match[g]);
    assign w_set_hit[g] = w_take && (w_idx == 1'(g));

    // Per-trigger mcontrol fields: software write, then hardware hit set wins
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
        r_dmode[g]  <= 1'b0;
        r_hit[g]    <= 1'b0;
        r_action[g] <= 1'b0;
        r_chain[g]  <= 1'b0;
        r_match[g]  <= '0;
        r_m[g]      <= 1'b0;
        r_exec[g]   <= 1'b0;
        r_store[g]  <= 1'b0;
        r_load[g]   <= 1'b0;
      end else begin
        if (mctrl_wr && w_wr_ok && (tselect == 1'(g))) begin
          if (dbg_mode) r_dmode[g] <= mctrl_wr_data[27];
          r_hit[g]    <= mctrl_wr_data[20];
          r_action[g] <= (mctrl_wr_data[15:12] == 4'd1);
          r_chain[g]  <= mctrl_wr_data[11];
          r_match[g]  <= mctrl_wr_data[10:7];
          r_m[g]      <= mctrl_wr_data[6];
          r_exec[g]   <= mctrl_wr_data[2];
          r_store[g]  <= mctrl_wr_data[1];
          r_load[g]   <= mctrl_wr_data[0];
        end
        if (w_set_hit[g]) r_hit[g] <= 1'b1;
      end
    end
  end

  // Chain qualification and priority: execute over load/store, trigger 0 over 1.
  // A chained trigger 0 only contributes as the partner of trigger 1.
  always_comb begin
    w_exe_fire    = '0;
    w_ls_fire     = '0;
    w_exe_fire[0] = w_exe_raw[0] && !r_chain[0];
    w_exe_fire[1] = w_exe_raw[1] && (!r_chain[0] || w_exe_raw[0]);
    w_ls_fire[0]  = w_ls_raw[0] && !r_chain[0];
    w_ls_fire[1]  = w_ls_raw[1] && (!r_chain[0] || w_ls_raw[0]);
    w_any         = (|w_exe_fire) || (|w_ls_fire);
    w_is_ls       = 1'b0;
    w_idx         = 1'b0;
    if (|w_exe_fire) begin
      w_idx = !w_exe_fire[0];
    end else if (|w_ls_fire) begin
      w_is_ls = 1'b1;
      w_idx   = !w_ls_fire[0];
    end
  end

  // Request FSM next state: capture only when idle, release on ack
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_take      = 1'b1;
          w_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (trig_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request state register
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Side outputs latch together with the rising request and hold while pending
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_trig_action <= 1'b0;
      r_trig_idx    <= 1'b0;
      r_trig_is_ls  <= 1'b0;
    end else if (w_take) begin
      r_trig_action <= r_action[w_idx];
      r_trig_idx    <= w_idx;
      r_trig_is_ls  <= w_is_ls;
    end
  end

  // mcontrol readback of the selected trigger; unimplemented fields read 0
  always_comb begin
    mctrl_rd_data        = '0;
    mctrl_rd_data[31:28] = 4'd2;
    mctrl_rd_data[27]    = r_dmode[tselect];
    mctrl_rd_data[20]    = r_hit[tselect];
    mctrl_rd_data[15:12] = {3'b000, r_action[tselect]};
    mctrl_rd_data[11]    = r_chain[tselect];
    mctrl_rd_data[10:7]  = r_match[tselect];
    mctrl_rd_data[6]     = r_m[tselect];
    mctrl_rd_data[2]     = r_exec[tselect];
    mctrl_rd_data[1]     = r_store[tselect];
    mctrl_rd_data[0]     = r_load[tselect];
  end

  assign trig_req    = (r_state == ST_PEND);
  assign trig_action = r_trig_action;
  assign trig_idx    = r_trig_idx;
  assign trig_is_ls  = r_trig_is_ls;

endmodule

// File: doc/trigger_match.md
Name: trigger_match

Overview:
- Consumer of the hardware trigger CSRs. Holds the per-trigger mcontrol (type 2) state and returns it as the tdata1 read value.
- Compares fetch PC and load/store address against tdata2 of trigger 0/1 every cycle.
- Issues a registered breakpoint-exception or debug-entry request that stays pending until acknowledged.
- Sits between the trigger CSR block and the core's trap/debug controller.

Parameters:
- NUM_TRIG, 2, number of triggers; only 2 supported, selected by a 1-bit tselect.
- DW, 32, data width; equals DATA_WIDTH.

Ports:
- cpu_clk  in  1  cpu clock
- cpu_rstn  in  1  async reset, active low
- tselect  in  1  selected trigger index
- mctrl_wr  in  1  write strobe for selected trigger's mcontrol; already resolved for set/clear
- mctrl_wr_data  in  DW  full new mcontrol value
- mctrl_rd_data  out  DW  mcontrol of selected trigger, combinational
- tdata2_t0  in  DW  compare value, trigger 0
- tdata2_t1  in  DW  compare value, trigger 1
- dbg_mode  in  1  core in debug mode
- if_pc_valid  in  1  fetch PC valid
- if_pc  in  DW  fetch PC
- ls_valid  in  1  load/store address valid
- ls_store  in  1  1 = store, 0 = load
- ls_addr  in  DW  load/store address
- trig_req  out  1  trigger fired, pending
- trig_action  out  1  0 = breakpoint exception, 1 = enter debug mode
- trig_idx  out  1  index of firing trigger
- trig_is_ls  out  1  fired on load/store (0 = execute)
- trig_ack  in  1  trap/debug controller accepted request

Behaviour:
- Per-trigger stored fields: dmode[27], hit[20], action[15:12], chain[11], match[10:7], m[6], execute[2], store[1], load[0].
- mcontrol read format:
  - type[31:28] reads 4'd2.
  - maskmax, select, timing, sizelo, s, u and all reserved bits read 0.
- Reset: all stored fields 0; trig_req, trig_action, trig_idx, trig_is_ls all 0.
- Write rules:
  - mctrl_wr updates the selected trigger's stored fields next cycle.
  - If the target's current dmode=1 and dbg_mode=0, the write is ignored.
  - dmode bit is written only when dbg_mode=1; otherwise it keeps its value.
  - action values other than 0/1 store as 0.
- Match compare, per trigger, per source (execute uses if_pc; load/store uses ls_addr):
  - match=0: equal.
  - match=2: value >= tdata2, unsigned.
  - match=3: value < tdata2, unsigned.
  - Any other match value never matches.
- Source enables:
  - Execute hit needs execute=1 and if_pc_valid.
  - LS hit needs ls_valid and (load & !ls_store | store & ls_store).
  - m=0 disables the trigger.
  - No matching while dbg_mode=1.
- Chain: if trigger0.chain=1, trigger0 does not fire alone; trigger1 fires only when both raw-match in the same cycle on the same source.
- Pipeline: compare results are registered. trig_req rises the cycle after the qualifying valid, with a latency of exactly 1.
- Priority within one cycle:
  - execute over load/store;
  - trigger 0 over trigger 1.
  - trig_idx, trig_is_ls and trig_action latch with trig_req.
- Handshake:
  - trig_req holds, with its side outputs stable, until a cycle with trig_ack=1; it clears the next cycle.
  - While trig_req=1 new matches are dropped; no queueing.
  - trig_ack with trig_req=0 is ignored.
  - A hit in the same cycle as the ack is dropped.
- Hit bit: set on the firing trigger when trig_req rises; software clears it via write. On a same-cycle conflict, the hardware set wins.
- dbg_mode rising while trig_req pending: the request stays pending until acked.
- Reset mid-request: trig_req and latched outputs return to 0 immediately (async).

Optional Feature:
- TRIGGER_NAPOT_MATCH_EN defined: match=1 (NAPOT) supported.
  - k = number of trailing ones in tdata2.
  - Compare value and tdata2 with the low k+1 bits masked.
  - tdata2 all-ones matches any address.
- Undefined: match=1 never matches; the stored field still reads back the written value.

Test Plan:
- Reset: after reset, mctrl_rd_data = 0x20000000 and trig_req = 0. Then write 0x0000_0044 (m, execute) to trigger0, tdata2_t0 = 0x100, drive if_pc = 0x100 valid → trig_req = 1 next cycle, trig_action = 0, trig_idx = 0, trig_is_ls = 0, hit bit reads 1.
- Chained load/store: trigger1 store with match=3, tdata2_t1 = 0x2000; trigger0 chain=1, match=2, tdata2_t0 = 0x1000; store to 0x1800 → trig_idx = 1, trig_is_ls = 1. Store to 0x2800 → no request.
- Handshake: hold trig_ack = 0 for 5 cycles while further matches arrive → outputs stable. trig_ack for 1 cycle → trig_req = 0 next cycle. Matches during pending are not reported.
- Debug-mode write protection: with dbg_mode = 1 write dmode = 1, action = 1. Write with dbg_mode = 0 → readback unchanged. Match with dbg_mode = 0 → trig_action = 1. No request while dbg_mode = 1.
- Simultaneous hits: execute hit on trigger1 and load hit on trigger0 in the same cycle → trig_is_ls = 0, trig_idx = 1.
- NAPOT (macro on): tdata2 = 0x0000_10FF, match = 1, address 0x1080 → hit; address 0x1200 → no hit. Macro off → no hit.
